// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath/memory side.
// master: controller; slave: datapath/memory (drives opcode and mem_ready).
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] state;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       branch_eq;
  logic       branch_ne;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       instr_done;
  logic [1:0] exc_cause;

  modport master (
    input  opcode, mem_ready,
    output state, mem_req, mem_write, iord, ir_write, pc_write, branch_eq, branch_ne,
           pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, exc_cause
  );

  modport slave (
    output opcode, mem_ready,
    input  state, mem_req, mem_write, iord, ir_write, pc_write, branch_eq, branch_ne,
           pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, exc_cause
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback sequencing
// with memory wait-state handshake, illegal-opcode trap and memory-timeout trap.
module mc_main_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 16
) (
  input logic          clk,
  input logic          rst,
  mc_main_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12,
    S_EXC    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     st, st_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic [1:0] exc_q, exc_nx;
  logic [2:0] imm_op, imm_nx;

  logic       mem_done;
  logic       timeout_hit;
  logic       in_mem_state;

  logic       mem_req, mem_write, iord, ir_write, pc_write;
  logic       branch_eq, branch_ne, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic       instr_done;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  assign mem_done     = (MEM_HANDSHAKE == 0) || bus.mem_ready;
  assign in_mem_state = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  // mem_ready on the final allowed cycle takes priority over the timeout
  assign timeout_hit  = (TIMEOUT != 0) && (MEM_HANDSHAKE != 0) && !bus.mem_ready &&
                        (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
      exc_q    <= EXC_NONE;
      imm_op   <= '0;
    end else begin
      st       <= st_nx;
      wait_cnt <= wait_nx;
      exc_q    <= exc_nx;
      imm_op   <= imm_nx;
    end
  end

  always_comb begin
    st_nx      = st;
    exc_nx     = exc_q;
    imm_nx     = imm_op;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    instr_done = 1'b0;

    case (st)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          st_nx    = S_DECODE;
        end else if (timeout_hit) begin
          st_nx  = S_EXC;
          exc_nx = EXC_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: st_nx = S_MEMADR;
          OP_RTYPE:     st_nx = S_REXEC;
          OP_BEQ:       st_nx = S_BEQ;
          OP_BNE:       st_nx = S_BNE;
          OP_J:         st_nx = S_JUMP;
          OP_ADDI: begin st_nx = S_IEXEC; imm_nx = 3'b000; end
          OP_SLTI: begin st_nx = S_IEXEC; imm_nx = 3'b101; end
          OP_ANDI: begin st_nx = S_IEXEC; imm_nx = 3'b110; end
          OP_ORI:  begin st_nx = S_IEXEC; imm_nx = 3'b011; end
          OP_XORI: begin st_nx = S_IEXEC; imm_nx = 3'b100; end
          default: begin st_nx = S_EXC;   exc_nx = EXC_ILLEGAL; end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        st_nx     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_done) begin
          st_nx = S_MEMWB;
        end else if (timeout_hit) begin
          st_nx  = S_EXC;
          exc_nx = EXC_TIMEOUT;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        st_nx      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_done) begin
          instr_done = 1'b1;
          st_nx      = S_FETCH;
        end else if (timeout_hit) begin
          st_nx  = S_EXC;
          exc_nx = EXC_TIMEOUT;
        end
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        st_nx     = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        st_nx      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_src     = 2'b01;
        branch_eq  = 1'b1;
        instr_done = 1'b1;
        st_nx      = S_FETCH;
      end
      S_BNE: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_src     = 2'b01;
        branch_ne  = 1'b1;
        instr_done = 1'b1;
        st_nx      = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_op;
        st_nx     = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        alu_op     = imm_op;
        instr_done = 1'b1;
        st_nx      = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        st_nx      = S_FETCH;
      end
      S_EXC: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
        st_nx    = S_FETCH;
      end
      default: st_nx = S_FETCH;
    endcase
  end

  // counter clears on any state change and saturates when the timeout is disabled
  always_comb begin
    wait_nx = wait_cnt;
    if (st_nx != st) begin
      wait_nx = '0;
    end else if (in_mem_state && !bus.mem_ready && (wait_cnt != '1)) begin
      wait_nx = wait_cnt + 8'd1;
    end
  end

  assign bus.state      = st;
  assign bus.mem_req    = mem_req;
  assign bus.mem_write  = mem_write;
  assign bus.iord       = iord;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.branch_eq  = branch_eq;
  assign bus.branch_ne  = branch_ne;
  assign bus.pc_src     = pc_src;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.instr_done = instr_done;
  assign bus.exc_cause  = exc_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: vector table on the default configuration,
// hand sequences for timeout, handshake-off and asynchronous reset.
module tb_mc_main_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mc_main_ctrl_if b0 ();
  mc_main_ctrl_if b1 ();
  mc_main_ctrl_if b2 ();

  mc_main_ctrl #(.MEM_HANDSHAKE(1), .TIMEOUT(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mc_main_ctrl #(.MEM_HANDSHAKE(1), .TIMEOUT(4))  u1 (.clk(clk), .rst(rst), .bus(b1));
  mc_main_ctrl #(.MEM_HANDSHAKE(0), .TIMEOUT(16)) u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, mem_req, mem_write, iord, ir_write, pc_write, branch_eq, branch_ne,
  //  pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done}
  logic [22:0] obs0, obs1, obs2;
  assign obs0 = {b0.state, b0.mem_req, b0.mem_write, b0.iord, b0.ir_write, b0.pc_write,
                 b0.branch_eq, b0.branch_ne, b0.pc_src, b0.reg_write, b0.reg_dst,
                 b0.mem_to_reg, b0.alu_src_a, b0.alu_src_b, b0.alu_op, b0.instr_done};
  assign obs1 = {b1.state, b1.mem_req, b1.mem_write, b1.iord, b1.ir_write, b1.pc_write,
                 b1.branch_eq, b1.branch_ne, b1.pc_src, b1.reg_write, b1.reg_dst,
                 b1.mem_to_reg, b1.alu_src_a, b1.alu_src_b, b1.alu_op, b1.instr_done};
  assign obs2 = {b2.state, b2.mem_req, b2.mem_write, b2.iord, b2.ir_write, b2.pc_write,
                 b2.branch_eq, b2.branch_ne, b2.pc_src, b2.reg_write, b2.reg_dst,
                 b2.mem_to_reg, b2.alu_src_a, b2.alu_src_b, b2.alu_op, b2.instr_done};

  function automatic logic [22:0] pk(input logic [3:0] st, input logic [6:0] memctl,
                                     input logic [1:0] pcs, input logic [3:0] wb,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic dn);
    return {st, memctl, pcs, wb, asb, aop, dn};
  endfunction

  function automatic logic [22:0] e_iex(input logic [2:0] aop);
    return pk(4'd9, 7'b0000000, 2'b00, 4'b0001, 2'b10, aop, 1'b0);
  endfunction

  function automatic logic [22:0] e_iwb(input logic [2:0] aop);
    return pk(4'd10, 7'b0000000, 2'b00, 4'b1000, 2'b00, aop, 1'b1);
  endfunction

  logic [22:0] F_W, F_D, DEC, MADR, MRD, MWB, MWR_W, MWR_D, REX, RWB, BEQ, BNE, JMP, EXC;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [22:0] exp;
    logic [1:0]  exc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [5:0] op, input logic rdy, input logic [22:0] exp,
                     input logic [1:0] exc);
    vecs.push_back({op, rdy, exp, exc});
  endtask

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BQ = 6'b000100,
                         BN = 6'b000101, JP = 6'b000010, ADDI = 6'b001000, SLTI = 6'b001010,
                         ANDI = 6'b001100, ORI = 6'b001101, XORI = 6'b001110, ILL = 6'b111111;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b0.opcode = '0; b0.mem_ready = 1'b0;
    b1.opcode = '0; b1.mem_ready = 1'b0;
    b2.opcode = '0; b2.mem_ready = 1'b0;

    F_W   = pk(4'd0,  7'b1000000, 2'b00, 4'b0000, 2'b01, 3'b000, 1'b0);
    F_D   = pk(4'd0,  7'b1001100, 2'b00, 4'b0000, 2'b01, 3'b000, 1'b0);
    DEC   = pk(4'd1,  7'b0000000, 2'b00, 4'b0000, 2'b11, 3'b000, 1'b0);
    MADR  = pk(4'd2,  7'b0000000, 2'b00, 4'b0001, 2'b10, 3'b000, 1'b0);
    MRD   = pk(4'd3,  7'b1010000, 2'b00, 4'b0000, 2'b00, 3'b000, 1'b0);
    MWB   = pk(4'd4,  7'b0000000, 2'b00, 4'b1010, 2'b00, 3'b000, 1'b1);
    MWR_W = pk(4'd5,  7'b1110000, 2'b00, 4'b0000, 2'b00, 3'b000, 1'b0);
    MWR_D = pk(4'd5,  7'b1110000, 2'b00, 4'b0000, 2'b00, 3'b000, 1'b1);
    REX   = pk(4'd6,  7'b0000000, 2'b00, 4'b0001, 2'b00, 3'b010, 1'b0);
    RWB   = pk(4'd7,  7'b0000000, 2'b00, 4'b1100, 2'b00, 3'b000, 1'b1);
    BEQ   = pk(4'd8,  7'b0000010, 2'b01, 4'b0001, 2'b00, 3'b001, 1'b1);
    BNE   = pk(4'd12, 7'b0000001, 2'b01, 4'b0001, 2'b00, 3'b001, 1'b1);
    JMP   = pk(4'd11, 7'b0000100, 2'b10, 4'b0000, 2'b00, 3'b000, 1'b1);
    EXC   = pk(4'd13, 7'b0000100, 2'b11, 4'b0000, 2'b00, 3'b000, 1'b0);

    // zero-wait instruction mix
    add(ADDI, 1, F_D, 0); add(ADDI, 0, DEC, 0); add(ADDI, 0, e_iex(3'b000), 0); add(ADDI, 0, e_iwb(3'b000), 0);
    add(RT, 1, F_D, 0);   add(RT, 0, DEC, 0);   add(RT, 0, REX, 0);           add(RT, 0, RWB, 0);
    add(LW, 1, F_D, 0);   add(LW, 0, DEC, 0);   add(LW, 0, MADR, 0); add(LW, 1, MRD, 0); add(LW, 0, MWB, 0);
    add(SW, 1, F_D, 0);   add(SW, 0, DEC, 0);   add(SW, 0, MADR, 0); add(SW, 1, MWR_D, 0);
    add(BQ, 1, F_D, 0);   add(BQ, 0, DEC, 0);   add(BQ, 0, BEQ, 0);
    add(JP, 1, F_D, 0);   add(JP, 0, DEC, 0);   add(JP, 0, JMP, 0);
    add(ORI, 1, F_D, 0);  add(ORI, 0, DEC, 0);  add(ORI, 0, e_iex(3'b011), 0);  add(ORI, 0, e_iwb(3'b011), 0);
    add(XORI, 1, F_D, 0); add(XORI, 0, DEC, 0); add(XORI, 0, e_iex(3'b100), 0); add(XORI, 0, e_iwb(3'b100), 0);
    add(SLTI, 1, F_D, 0); add(SLTI, 0, DEC, 0); add(SLTI, 0, e_iex(3'b101), 0); add(SLTI, 0, e_iwb(3'b101), 0);
    add(ANDI, 1, F_D, 0); add(ANDI, 0, DEC, 0); add(ANDI, 0, e_iex(3'b110), 0); add(ANDI, 0, e_iwb(3'b110), 0);
    add(BN, 1, F_D, 0);   add(BN, 0, DEC, 0);   add(BN, 0, BNE, 0);
    // wait states in fetch and store, then a load held three cycles in MEMRD
    add(SW, 0, F_W, 0);   add(SW, 1, F_D, 0);   add(SW, 0, DEC, 0); add(SW, 0, MADR, 0);
    add(SW, 0, MWR_W, 0); add(SW, 1, MWR_D, 0);
    add(LW, 1, F_D, 0);   add(LW, 0, DEC, 0);   add(LW, 0, MADR, 0);
    add(LW, 0, MRD, 0);   add(LW, 0, MRD, 0);   add(LW, 0, MRD, 0); add(LW, 1, MRD, 0); add(LW, 0, MWB, 0);
    // illegal opcode trap
    add(ILL, 1, F_D, 0);  add(ILL, 0, DEC, 0);  add(ILL, 0, EXC, 2'b01); add(ILL, 0, F_W, 2'b01);

    @(negedge clk);
    #1;
    chk("reset u0 ctrl", obs0, F_W);
    chk("reset u0 exc", 23'(b0.exc_cause), 23'd0);
    chk("reset u1 ctrl", obs1, F_W);
    chk("reset u2 state", 23'(b2.state), 23'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      b0.opcode    = vecs[i].op;
      b0.mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d ctrl", i), obs0, vecs[i].exp);
      chk($sformatf("vec%0d exc", i), 23'(b0.exc_cause), 23'(vecs[i].exc));
      @(negedge clk);
    end

    // asynchronous reset in the middle of a MEMRD wait; exc_cause is 01 beforehand
    b0.opcode = LW; b0.mem_ready = 1'b1; #1; chk("rstseq fetch", obs0, F_D); @(negedge clk);
    b0.mem_ready = 1'b0; #1; chk("rstseq decode", obs0, DEC); @(negedge clk);
    #1; chk("rstseq memadr", obs0, MADR); @(negedge clk);
    #1; chk("rstseq memrd", obs0, MRD); @(negedge clk);
    #1; chk("rstseq memrd wait", obs0, MRD);
    #1; rst = 1'b1;
    #1;
    chk("async rst ctrl", obs0, F_W);
    chk("async rst exc", 23'(b0.exc_cause), 23'd0);
    chk("async rst reg_write", 23'(b0.reg_write), 23'd0);
    @(negedge clk);
    #1; chk("rst held ctrl", obs0, F_W);
    rst = 1'b0;

    // TIMEOUT=4: fetch never completes
    do_reset();
    b1.opcode = ADDI; b1.mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1; chk($sformatf("to fetch wait%0d", c), obs1, F_W); @(negedge clk);
    end
    #1; chk("to exc ctrl", obs1, EXC); chk("to exc cause", 23'(b1.exc_cause), 23'd2);
    @(negedge clk);
    #1; chk("to back to fetch", obs1, F_W); chk("to cause held", 23'(b1.exc_cause), 23'd2);
    @(negedge clk);
    // counter restarted in the new FETCH: three misses then ready on the final cycle
    #1; chk("to second wait1", obs1, F_W); @(negedge clk);
    #1; chk("to second wait2", obs1, F_W); @(negedge clk);
    b1.mem_ready = 1'b1;
    #1; chk("to ready on last", obs1, F_D); @(negedge clk);
    b1.mem_ready = 1'b0;
    #1; chk("to decode after ready", obs1, DEC); chk("to cause still", 23'(b1.exc_cause), 23'd2);

    // handshake disabled, mem_ready tied low
    do_reset();
    b2.opcode = LW; b2.mem_ready = 1'b0;
    #1; chk("nohs fetch", obs2, F_D); @(negedge clk);
    #1; chk("nohs decode", obs2, DEC); @(negedge clk);
    #1; chk("nohs memadr", obs2, MADR); @(negedge clk);
    #1; chk("nohs memrd", obs2, MRD); @(negedge clk);
    #1; chk("nohs memwb", obs2, MWB); @(negedge clk);
    #1; chk("nohs next fetch", obs2, F_D);
    b2.opcode = SW;
    repeat (20) @(negedge clk);
    #1; chk("nohs no timeout", 23'(b2.exc_cause), 23'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
